mdu_issue_controller: RTL and testbench
=======================================

// Module: mdu_issue_controller
// PURPOSE
//  Sequences pipeline multiply/divide/HI-LO traffic onto the single multiplication-division unit (MDU).
//  Sits between the execute stage and the MDU. It owns the MDU operation/start/operand inputs.
//  Start and write ops are fire-and-forget through a small in-order issue queue.
//  HI/LO reads stall until every older op has completed; the pipeline sees only a valid/ready handshake.
// PARAMETERS
//  QUEUE_DEPTH  2   issue-queue entries for start/write ops (power of two, >=2)
//  DATA_WIDTH   32  operand/result width (matches int_t)
// PORTS
//  clock         in   1           single clock, rising edge
//  reset         in   1           asynchronous, active-low reset
//  reqValid      in   1           execute stage presents an MDU op
//  reqOp         in   3           mdu_operation_t (READ_HI/LO, WRITE_HI/LO, START_*)
//  reqOperand1   in   DATA_WIDTH  operand 1 (WRITE_* value = operand 1)
//  reqOperand2   in   DATA_WIDTH  operand 2
//  flush         in   1           kill the op presented this cycle (exception/branch squash)
//  reqReady      out  1           op accepted this cycle (handshake = reqValid & reqReady & !flush)
//  readData      out  DATA_WIDTH  HI/LO value; valid in the cycle a READ_* is accepted
//  pending       out  1           queue non-empty or MDU busy
//  stallCycles   out  32          saturating count of cycles with reqValid & !reqReady
//  mduOperation  out  3           to MDU operation
//  mduStart      out  1           to MDU start
//  mduOperand1   out  DATA_WIDTH  to MDU operand1
//  mduOperand2   out  DATA_WIDTH  to MDU operand2
//  mduBusy       in   1           from MDU busy
//  mduDataRead   in   DATA_WIDTH  from MDU dataRead
// BEHAVIOUR
//  Reset (async, reset==0): queue empty, head/tail pointers 0, count 0, stallCycles 0.
//   All outputs are combinational from that state: reqReady per rules below, pending = mduBusy,
//   mduStart = 0, mduOperation = MDU_READ_HI, operands 0.
//  Reset mid-operation drops all queued ops. The top level resets the MDU from the same source.
//  Issue state is idle or draining (count != 0).
//  MDU "free" = !mduBusy. A start issued in cycle N raises mduBusy from N+1.
//   HI/LO written at an edge are readable in the next cycle.
//  Drive priority each cycle (one MDU op per cycle):
//   1. Queue non-empty & free: drive head entry, mduStart = head is START_*, pop.
//   2. Else queue empty & free & reqValid & !flush: drive the request directly (bypass).
//      READ_*: readData = mduDataRead, reqReady = 1.
//      WRITE_*/START_*: issued same cycle, reqReady = 1, nothing enqueued.
//   3. Else mduOperation = MDU_READ_HI, mduStart = 0, operands 0 (idle; the MDU ignores reads).
//  Acceptance when not bypassed:
//   WRITE_*/START_*: reqReady = (count < QUEUE_DEPTH); enqueue at tail on handshake.
//   Pop and push in the same cycle are allowed; count is unchanged.
//   READ_*: reqReady = 0 until queue empty & free (ordering: a read sees all older ops).
//  Full queue: reqReady = 0 for start/write. No overwrite; the pipeline holds its request.
//  Pointers wrap modulo QUEUE_DEPTH. count spans 0..QUEUE_DEPTH (log2(DEPTH)+1 bits).
//  flush: reqReady forced 0 and nothing enqueued or bypassed that cycle.
//   Queued entries and the in-flight MDU op are architecturally committed and unaffected.
//  readData = 0 whenever no READ_* is accepted.
//  stallCycles: +1 per cycle with reqValid & !reqReady & !flush; holds at 32'hFFFF_FFFF.
//  pending = (count != 0) | mduBusy.
//  Divide-by-zero is not special-cased here; the MDU leaves HI/LO unchanged.
// STRUCTURE
//  Shared package: mdu_operation_t (moved out of the MDU file).
//   Helper functions isMduStart(op), isMduWrite(op), isMduRead(op).
//   Issue-queue entry typedef {op, operand1, operand2}.
//  Sub-module: mdu_issue_queue. Parameterised FIFO with push/pop/full/empty/count,
//   head visible combinationally, async active-low reset.
//  Controller logic (priority mux, handshake, stall counter) lives in this module.
// TESTING
//  Bench instantiates this block plus the real MDU (MDU reset = !reset).
//  1. MULT 7 x -3 bypass, then MFLO, MFHI: MFLO stalls 5 cycles -> 32'hFFFF_FFEB; MFHI 32'hFFFF_FFFF.
//  2. DIVU 100/7 then MTHI 5 while busy: MTHI queued, issues when busy drops, overrides remainder.
//     MFHI -> 5; MFLO -> 14.
//  3. Three back-to-back MTLO (DEPTH=2) behind a 10-cycle DIV: third sees reqReady=0 until a pop.
//     Final MFLO = last value; stallCycles matches stalled cycles.
//  4. flush asserted with MULT 2x3 on the request while a prior MTHI is queued:
//     MULT never starts (mduStart stays 0 for it), MTHI still lands, pending falls.
//  5. Reset (low) 3 cycles into a DIV with 2 entries queued:
//     count=0, pending=0 after MDU reset, stallCycles=0, next MFHI returns 0.
//  6. DIV 5/0 then MFLO: after 10 cycles MFLO returns the prior LO (e.g. 0x1234 from an earlier MTLO).

Source files
------------

// File: rtl/mdu_issue_controller_pkg.sv
// Shared MDU types: operation encoding, issue-queue entry and operation class helpers.
package mdu_issue_controller_pkg;

    localparam int MDU_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_READ_HI     = 3'd0,
        MDU_READ_LO     = 3'd1,
        MDU_WRITE_HI    = 3'd2,
        MDU_WRITE_LO    = 3'd3,
        MDU_START_MULT  = 3'd4,
        MDU_START_MULTU = 3'd5,
        MDU_START_DIV   = 3'd6,
        MDU_START_DIVU  = 3'd7
    } mdu_operation_t;

    typedef struct packed {
        mdu_operation_t            op;
        logic [MDU_DATA_WIDTH-1:0] operand1;
        logic [MDU_DATA_WIDTH-1:0] operand2;
    } issue_entry_t;

    function automatic logic isMduStart(input mdu_operation_t op);
        return op[2];
    endfunction

    function automatic logic isMduWrite(input mdu_operation_t op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic isMduRead(input mdu_operation_t op);
        return (op[2:1] == 2'b00);
    endfunction

endpackage

// File: rtl/mdu_issue_controller_if.sv
// Execute-stage request channel into the MDU issue controller.
interface mdu_issue_controller_if #(
    parameter int DATA_WIDTH = 32
);
    import mdu_issue_controller_pkg::*;

    logic                  reqValid;
    mdu_operation_t        reqOp;
    logic [DATA_WIDTH-1:0] reqOperand1;
    logic [DATA_WIDTH-1:0] reqOperand2;
    logic                  flush;
    logic                  reqReady;
    logic [DATA_WIDTH-1:0] readData;

    modport master (
        output reqValid, reqOp, reqOperand1, reqOperand2, flush,
        input  reqReady, readData
    );

    modport slave (
        input  reqValid, reqOp, reqOperand1, reqOperand2, flush,
        output reqReady, readData
    );

endinterface

// File: rtl/mdu_issue_queue.sv
// In-order FIFO of pending MDU start/write ops; head entry is visible combinationally.
module mdu_issue_queue
    import mdu_issue_controller_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = issue_entry_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_DEPTH);
    assign count     = count_r;
    assign head      = mem_r[head_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and occupancy tracking; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (do_pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[tail_r] <= push_data;
        end
    end

endmodule

// File: rtl/mdu_issue_controller.sv
// Sequences execute-stage multiply/divide/HI-LO ops onto the single MDU, keeping reads ordered.
module mdu_issue_controller
    import mdu_issue_controller_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    mdu_issue_controller_if.slave  req,
    output logic                   pending,
    output logic [31:0]            stallCycles,
    output mdu_operation_t         mduOperation,
    output logic                   mduStart,
    output logic [DATA_WIDTH-1:0]  mduOperand1,
    output logic [DATA_WIDTH-1:0]  mduOperand2,
    input  logic                   mduBusy,
    input  logic [DATA_WIDTH-1:0]  mduDataRead
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        mdu_operation_t        op;
        logic [DATA_WIDTH-1:0] operand1;
        logic [DATA_WIDTH-1:0] operand2;
    } entry_t;

    entry_t                q_head_s;
    entry_t                q_push_data_s;
    logic                  q_full_s;
    logic                  q_empty_s;
    logic [CNT_W-1:0]      q_count_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  bypass_s;
    logic                  free_s;
    logic                  req_live_s;
    logic                  req_ready_s;
    logic [DATA_WIDTH-1:0] read_data_s;
    mdu_operation_t        mdu_op_s;
    logic                  mdu_start_s;
    logic [DATA_WIDTH-1:0] mdu_op1_s;
    logic [DATA_WIDTH-1:0] mdu_op2_s;
    logic [31:0]           stall_r;

    assign free_s        = ~mduBusy;
    assign req_live_s    = req.reqValid & ~req.flush;
    assign q_push_data_s = '{op: req.reqOp, operand1: req.reqOperand1, operand2: req.reqOperand2};

    mdu_issue_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (q_push_data_s),
        .pop       (pop_s),
        .head      (q_head_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (q_count_s)
    );

    // MDU drive priority (queued head, then bypass, then idle) and request handshake.
    always_comb begin
        pop_s       = 1'b0;
        push_s      = 1'b0;
        bypass_s    = 1'b0;
        req_ready_s = 1'b0;
        read_data_s = '0;
        mdu_op_s    = MDU_READ_HI;
        mdu_start_s = 1'b0;
        mdu_op1_s   = '0;
        mdu_op2_s   = '0;

        if (!q_empty_s && free_s) begin
            mdu_op_s    = q_head_s.op;
            mdu_start_s = isMduStart(q_head_s.op);
            mdu_op1_s   = q_head_s.operand1;
            mdu_op2_s   = q_head_s.operand2;
            pop_s       = 1'b1;
        end else if (q_empty_s && free_s && req_live_s) begin
            mdu_op_s    = req.reqOp;
            mdu_start_s = isMduStart(req.reqOp);
            mdu_op1_s   = req.reqOperand1;
            mdu_op2_s   = req.reqOperand2;
            bypass_s    = 1'b1;
        end else begin
            mdu_op_s    = MDU_READ_HI;
            mdu_start_s = 1'b0;
        end

        if (bypass_s) begin
            req_ready_s = 1'b1;
            if (isMduRead(req.reqOp)) begin
                read_data_s = mduDataRead;
            end else begin
                read_data_s = '0;
            end
        end else if (req.flush) begin
            req_ready_s = 1'b0;
        end else if (isMduRead(req.reqOp)) begin
            // Reads wait for an empty queue and an idle MDU so they observe every older op.
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = ~q_full_s;
        end

        push_s = req_live_s & req_ready_s & ~bypass_s & ~isMduRead(req.reqOp);
    end

    // Saturating count of cycles the pipeline was held off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_r <= 32'd0;
        end else if (req_live_s && !req_ready_s && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign req.reqReady = req_ready_s;
    assign req.readData = read_data_s;
    assign pending      = (q_count_s != '0) | mduBusy;
    assign stallCycles  = stall_r;
    assign mduOperation = mdu_op_s;
    assign mduStart     = mdu_start_s;
    assign mduOperand1  = mdu_op1_s;
    assign mduOperand2  = mdu_op2_s;

endmodule

// File: tb/tb_mdu_issue_controller.sv
// Scoreboard bench: issue controller driving a behavioural MDU (5-cycle multiply, 10-cycle divide).
module tb_mdu_issue_controller;
    import mdu_issue_controller_pkg::*;

    localparam int BUDGET = 60;

    logic           clock;
    logic           reset;
    logic           pending;
    logic [31:0]    stallCycles;
    mdu_operation_t mduOperation;
    logic           mduStart;
    logic [31:0]    mduOperand1;
    logic [31:0]    mduOperand2;
    logic           mduBusy;
    logic [31:0]    mduDataRead;

    int          checks;
    int          failures;
    int          sb_stalls;
    int          mult23_starts;
    logic [31:0] exp_q [$];

    mdu_issue_controller_if #(.DATA_WIDTH(32)) rq ();

    mdu_issue_controller #(
        .QUEUE_DEPTH (2),
        .DATA_WIDTH  (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (rq.slave),
        .pending      (pending),
        .stallCycles  (stallCycles),
        .mduOperation (mduOperation),
        .mduStart     (mduStart),
        .mduOperand1  (mduOperand1),
        .mduOperand2  (mduOperand2),
        .mduBusy      (mduBusy),
        .mduDataRead  (mduDataRead)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural MDU
    logic [31:0]    hi_r, lo_r, a_r, b_r;
    mdu_operation_t op_r;
    int             cnt_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_r <= 32'd0; lo_r <= 32'd0; a_r <= 32'd0; b_r <= 32'd0;
            op_r <= MDU_READ_HI; cnt_r <= 0; mduBusy <= 1'b0;
        end else if (mduBusy) begin
            if (cnt_r == 1) begin
                mduBusy <= 1'b0;
                case (op_r)
                    MDU_START_MULT:  {hi_r, lo_r} <= {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
                    MDU_START_MULTU: {hi_r, lo_r} <= {32'd0, a_r} * {32'd0, b_r};
                    MDU_START_DIV: if (b_r != 32'd0) begin
                        lo_r <= $signed(a_r) / $signed(b_r);
                        hi_r <= $signed(a_r) % $signed(b_r);
                    end
                    MDU_START_DIVU: if (b_r != 32'd0) begin
                        lo_r <= a_r / b_r;
                        hi_r <= a_r % b_r;
                    end
                    default: ;
                endcase
            end else begin
                cnt_r <= cnt_r - 1;
            end
        end else if (mduStart) begin
            mduBusy <= 1'b1;
            op_r    <= mduOperation;
            a_r     <= mduOperand1;
            b_r     <= mduOperand2;
            cnt_r   <= (mduOperation == MDU_START_DIV || mduOperation == MDU_START_DIVU) ? 10 : 5;
        end else if (mduOperation == MDU_WRITE_HI) begin
            hi_r <= mduOperand1;
        end else if (mduOperation == MDU_WRITE_LO) begin
            lo_r <= mduOperand1;
        end
    end

    always_comb mduDataRead = (mduOperation == MDU_READ_LO) ? lo_r : hi_r;

    always @(posedge clock) begin
        if (mduStart && mduOperand1 == 32'd2 && mduOperand2 == 32'd3) mult23_starts <= mult23_starts + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one op from posedge+1; returns stall cycles seen before the handshake.
    task automatic issue(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        logic done;
        rq.reqValid = 1'b1; rq.reqOp = op; rq.reqOperand1 = a; rq.reqOperand2 = b; rq.flush = 1'b0;
        stalls = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clock);
            if (rq.reqReady) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > BUDGET) begin
                    check_value("handshake_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        if (isMduRead(op) && rq.reqReady && exp_q.size() > 0) begin
            check_value(op == MDU_READ_HI ? "readData_hi" : "readData_lo", rq.readData, exp_q.pop_front());
        end
        sb_stalls += stalls;
        @(posedge clock); #1;
        rq.reqValid = 1'b0;
    endtask

    task automatic read_expect(input string tag, input mdu_operation_t op, input logic [31:0] exp,
                               input int exp_stalls);
        int st;
        exp_q.push_back(exp);
        issue(op, 32'd0, 32'd0, st);
        if (exp_stalls >= 0) check_value(tag, st, exp_stalls);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (pending && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        check_value("drain_pending", {31'd0, pending}, 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int st;
        int ready_seen;
        checks = 0; failures = 0; sb_stalls = 0; mult23_starts = 0;
        rq.reqValid = 1'b0; rq.reqOp = MDU_READ_HI; rq.reqOperand1 = 32'd0; rq.reqOperand2 = 32'd0;
        rq.flush = 1'b0;
        reset = 1'b0;
        #2;
        check_value("rst_pending", {31'd0, pending}, 32'd0);
        check_value("rst_stall", stallCycles, 32'd0);
        check_value("rst_start", {31'd0, mduStart}, 32'd0);
        check_value("rst_op", {29'd0, mduOperation}, {29'd0, MDU_READ_HI});
        check_value("rst_operand1", mduOperand1, 32'd0);
        check_value("rst_ready_noreq", {31'd0, rq.reqReady}, 32'd0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // 1: MULT 7 x -3 bypassed, then reads
        issue(MDU_START_MULT, 32'd7, 32'hFFFF_FFFD, st);
        check_value("mult_bypass_stall", st, 32'd0);
        read_expect("mflo_stall", MDU_READ_LO, 32'hFFFF_FFEB, 5);
        read_expect("mfhi_stall", MDU_READ_HI, 32'hFFFF_FFFF, 0);
        @(negedge clock);
        check_value("idle_readData", rq.readData, 32'd0);
        @(posedge clock); #1;

        // 2: DIVU then queued MTHI overriding the remainder
        issue(MDU_START_DIVU, 32'd100, 32'd7, st);
        issue(MDU_WRITE_HI, 32'd5, 32'd0, st);
        check_value("mthi_queued_stall", st, 32'd0);
        check_value("mthi_pending", {31'd0, pending}, 32'd1);
        read_expect("mfhi_after_div", MDU_READ_HI, 32'd5, 10);
        read_expect("mflo_after_div", MDU_READ_LO, 32'd14, 0);

        // 3: three MTLO behind a DIV with a two-entry queue
        issue(MDU_START_DIV, 32'd50, 32'd3, st);
        issue(MDU_WRITE_LO, 32'd1, 32'd0, st);
        check_value("mtlo1_stall", st, 32'd0);
        issue(MDU_WRITE_LO, 32'd2, 32'd0, st);
        check_value("mtlo2_stall", st, 32'd0);
        issue(MDU_WRITE_LO, 32'd3, 32'd0, st);
        check_value("mtlo3_full_stall", st, 32'd9);
        read_expect("mflo_last", MDU_READ_LO, 32'd3, -1);
        read_expect("mfhi_div_rem", MDU_READ_HI, 32'd2, 0);
        check_value("stallCycles_t3", stallCycles, sb_stalls);

        // 4: flushed MULT 2x3 while an MTHI is queued
        issue(MDU_START_MULT, 32'd1, 32'd1, st);
        issue(MDU_WRITE_HI, 32'h0000_ABCD, 32'd0, st);
        rq.reqValid = 1'b1; rq.reqOp = MDU_START_MULT; rq.reqOperand1 = 32'd2; rq.reqOperand2 = 32'd3;
        rq.flush = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rq.reqReady) ready_seen++;
        end
        @(posedge clock); #1;
        rq.reqValid = 1'b0; rq.flush = 1'b0;
        check_value("flush_ready", ready_seen, 32'd0);
        @(negedge clock);
        check_value("flush_pending", {31'd0, pending}, 32'd0);
        check_value("flush_no_start", mult23_starts, 32'd0);
        @(posedge clock); #1;
        read_expect("mfhi_after_flush", MDU_READ_HI, 32'h0000_ABCD, 0);
        check_value("stallCycles_t4", stallCycles, sb_stalls);

        // 5: reset during a DIV with two queued writes
        issue(MDU_START_DIV, 32'd40, 32'd4, st);
        issue(MDU_WRITE_LO, 32'd7, 32'd0, st);
        issue(MDU_WRITE_LO, 32'd8, 32'd0, st);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_value("midrst_pending", {31'd0, pending}, 32'd0);
        check_value("midrst_stall", stallCycles, 32'd0);
        check_value("midrst_start", {31'd0, mduStart}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        sb_stalls = 0;
        @(posedge clock); #1;
        read_expect("mfhi_post_rst", MDU_READ_HI, 32'd0, 0);
        read_expect("mflo_post_rst", MDU_READ_LO, 32'd0, 0);

        // 6: divide by zero leaves LO untouched
        issue(MDU_WRITE_LO, 32'h0000_1234, 32'd0, st);
        issue(MDU_START_DIV, 32'd5, 32'd0, st);
        read_expect("mflo_div0", MDU_READ_LO, 32'h0000_1234, 10);
        wait_idle();
        check_value("stallCycles_final", stallCycles, sb_stalls);
        check_value("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
